// File: rtl/vadd_hls_system.sv
// ---------------------------------------------------------------------------
// vadd_hls_system
//   System wrapper for an element-wise vector adder, C[i] = A[i] + B[i].
//   Three single-port block RAMs (A, B, C) feed a small sequencing kernel
//   that runs once after reset release and then raises a sticky done flag.
//
//   Build option:
//     ADD_SAT_EN  - when defined, the adder saturates to all-ones instead of
//                   wrapping modulo 2^DATA_W. Timing is identical either way.
//
//   Ports (top):
//     sys_clk  in   system clock, rising edge
//     sys_rst  in   asynchronous active-low reset
//     done     out  completion flag (same net as ctrl_intf_1_done)
//
//   Ports (vadd_hls_bram):
//     clk_i    in   clock
//     en_i     in   port enable (read and/or write)
//     we_i     in   write enable
//     addr_i   in   word address
//     wdata_i  in   write data
//     rdata_o  out  registered read data, one cycle latency
// ---------------------------------------------------------------------------

// Single-port RAM; contents are deliberately not reset so preloaded data survives.
module vadd_hls_bram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] bram [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read-before-write single port access
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                bram[addr_i] <= wdata_i;
            end
            rdata_q <= bram[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

module vadd_hls_system #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] index_q;
    logic              ap_start_q;
    logic              done_q;
    logic              ctrl_intf_1_done;

    logic              ab_en;
    logic              c_we;
    logic [DATA_W-1:0] a_rdata;
    logic [DATA_W-1:0] b_rdata;
    logic [DATA_W-1:0] c_rdata_unused;
    logic [DATA_W-1:0] sum_c;

    // Kernel sequencer: IDLE -> (RD -> WR) x DEPTH -> DONE
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            ap_start_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ap_start_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    ap_start_q <= 1'b1;
                    state_q    <= ST_RD;
                end
                ST_RD: begin
                    // A fresh start always begins at element 0
                    if (ap_start_q) begin
                        index_q <= '0;
                    end
                    state_q <= ST_WR;
                end
                ST_WR: begin
                    if (index_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                    end else begin
                        index_q <= index_q + ADDR_W'(1);
                        state_q <= ST_RD;
                    end
                end
                ST_DONE: begin
                    // Flag lands one edge after the last write, then sticks
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM strobes decode directly from the registered state
    assign ab_en = (state_q == ST_RD);
    assign c_we  = (state_q == ST_WR);

    // Element adder
`ifdef ADD_SAT_EN
    logic [DATA_W:0] sum_wide;
    assign sum_wide = {1'b0, a_rdata} + {1'b0, b_rdata};
    assign sum_c    = sum_wide[DATA_W] ? {DATA_W{1'b1}} : sum_wide[DATA_W-1:0];
`else
    assign sum_c = a_rdata + b_rdata;
`endif

    vadd_hls_bram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) Block_Memory (
        .clk_i   (sys_clk),
        .en_i    (ab_en),
        .we_i    (1'b0),
        .addr_i  (index_q),
        .wdata_i ({DATA_W{1'b0}}),
        .rdata_o (a_rdata)
    );

    vadd_hls_bram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) Block_Memory_1 (
        .clk_i   (sys_clk),
        .en_i    (ab_en),
        .we_i    (1'b0),
        .addr_i  (index_q),
        .wdata_i ({DATA_W{1'b0}}),
        .rdata_o (b_rdata)
    );

    vadd_hls_bram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) Block_Memory_2 (
        .clk_i   (sys_clk),
        .en_i    (c_we),
        .we_i    (c_we),
        .addr_i  (index_q),
        .wdata_i (sum_c),
        .rdata_o (c_rdata_unused)
    );

    assign ctrl_intf_1_done = done_q;
    assign done             = ctrl_intf_1_done;

endmodule

// File: tb/tb_vadd_hls_system.sv
// ---------------------------------------------------------------------------
// tb_vadd_hls_system
//   Self-checking bench for vadd_hls_system. RAMs are preloaded and inspected
//   hierarchically; expected sums come from a plain arithmetic model.
// ---------------------------------------------------------------------------
module tb_vadd_hls_system;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 8;
    localparam int          LATENCY = 2 * DEPTH + 2;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    logic done;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] a_m [DEPTH];
    logic [31:0] b_m [DEPTH];
    logic [31:0] c_m [DEPTH];

    vadd_hls_system #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .done    (done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] s;
        s = {32'd0, a} + {32'd0, b};
`ifdef ADD_SAT_EN
        return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
`else
        return s[31:0];
`endif
    endfunction

    task automatic preload();
        for (int i = 0; i < DEPTH; i++) begin
            dut.Block_Memory.bram[i]   = a_m[i];
            dut.Block_Memory_1.bram[i] = b_m[i];
            dut.Block_Memory_2.bram[i] = c_m[i];
        end
    endtask

    task automatic enter_reset();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        check_eq("done_in_reset", 64'(done), 64'd0);
    endtask

    // Release reset and return the rising-edge index where done first reads high (0 = timeout)
    task automatic release_and_time(output int edge_n);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        edge_n  = 0;
        for (int k = 1; k <= 4 * LATENCY; k++) begin
            @(posedge sys_clk);
            #1;
            if (done) begin
                edge_n = k;
                break;
            end
        end
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            check_eq({tag, "_C"}, 64'(dut.Block_Memory_2.bram[i]), 64'(ref_add(a_m[i], b_m[i])));
            check_eq({tag, "_A"}, 64'(dut.Block_Memory.bram[i]), 64'(a_m[i]));
            check_eq({tag, "_B"}, 64'(dut.Block_Memory_1.bram[i]), 64'(b_m[i]));
        end
    endtask

    task automatic full_run(input string tag);
        int edge_n;
        enter_reset();
        preload();
        repeat (2) @(negedge sys_clk);
        release_and_time(edge_n);
        check_eq({tag, "_latency"}, 64'(edge_n), 64'(LATENCY));
        check_ram(tag);
    endtask

    initial begin
        int          edge_n;
        int unsigned low_cnt;
        int unsigned high_cnt;
        logic [31:0] exp7;

        // Test 1: A=i, B=i, C=0 preloaded at t=0 under reset
        for (int i = 0; i < DEPTH; i++) begin
            a_m[i] = 32'(i);
            b_m[i] = 32'(i);
            c_m[i] = 32'd0;
        end
        preload();
        #1;
        check_eq("reset_done", 64'(done), 64'd0);
        #9;
        release_and_time(edge_n);
        check_eq("t1_latency", 64'(edge_n), 64'(LATENCY));
        for (int i = 0; i < DEPTH; i++) begin
            check_eq("t1_C_2i", 64'(dut.Block_Memory_2.bram[i]), 64'(2 * i));
        end
        check_ram("t1");
        // done must stay high for 100 more cycles
        low_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge sys_clk);
            #1;
            if (!done) low_cnt++;
        end
        check_eq("t1_done_held", 64'(low_cnt), 64'd0);

        // Test 2: wrap/saturate boundary on the last element
        for (int i = 0; i < DEPTH; i++) begin
            a_m[i] = $urandom;
            b_m[i] = $urandom;
            c_m[i] = 32'd0;
        end
        a_m[DEPTH-1] = 32'hFFFF_FFFF;
        b_m[DEPTH-1] = 32'd2;
`ifdef ADD_SAT_EN
        exp7 = 32'hFFFF_FFFF;
`else
        exp7 = 32'd1;
`endif
        full_run("t2");
        check_eq("t2_C7_boundary", 64'(dut.Block_Memory_2.bram[DEPTH-1]), 64'(exp7));

        // Test 3: reset after edge 7, then rerun
        for (int i = 0; i < DEPTH; i++) begin
            a_m[i] = $urandom;
            b_m[i] = $urandom;
            c_m[i] = 32'hDEAD_BEEF;
        end
        enter_reset();
        preload();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (7) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        #1;
        check_eq("t3_done_async_clr", 64'(done), 64'd0);
        // Writes at edges 3, 5, 7 covered elements 0..2
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 3)
                check_eq("t3_C_partial", 64'(dut.Block_Memory_2.bram[i]), 64'(ref_add(a_m[i], b_m[i])));
            else
                check_eq("t3_C_untouched", 64'(dut.Block_Memory_2.bram[i]), 64'h0000_0000_DEAD_BEEF);
        end
        high_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk);
            if (done) high_cnt++;
        end
        check_eq("t3_done_low_rst", 64'(high_cnt), 64'd0);
        release_and_time(edge_n);
        check_eq("t3_latency2", 64'(edge_n), 64'(LATENCY));
        check_ram("t3");

        // Test 4: reset held 50 cycles leaves C alone
        for (int i = 0; i < DEPTH; i++) begin
            a_m[i] = $urandom;
            b_m[i] = $urandom;
            c_m[i] = 32'hDEAD_BEEF;
        end
        enter_reset();
        preload();
        high_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge sys_clk);
            if (done) high_cnt++;
        end
        check_eq("t4_done_low", 64'(high_cnt), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            check_eq("t4_C_kept", 64'(dut.Block_Memory_2.bram[i]), 64'h0000_0000_DEAD_BEEF);
        end
        release_and_time(edge_n);
        check_eq("t4_latency", 64'(edge_n), 64'(LATENCY));
        check_ram("t4");

        // Test 5: A=100+i, B=7i; nothing written after done
        for (int i = 0; i < DEPTH; i++) begin
            a_m[i] = 32'(100 + i);
            b_m[i] = 32'(7 * i);
            c_m[i] = 32'd0;
        end
        full_run("t5");
        for (int i = 0; i < DEPTH; i++) begin
            check_eq("t5_C_100_8i", 64'(dut.Block_Memory_2.bram[i]), 64'(100 + 8 * i));
        end
        for (int i = 0; i < DEPTH; i++) begin
            dut.Block_Memory_2.bram[i] = 32'h5A5A_0000 + 32'(i);
        end
        repeat (20) @(negedge sys_clk);
        for (int i = 0; i < DEPTH; i++) begin
            check_eq("t5_no_write_after_done", 64'(dut.Block_Memory_2.bram[i]), 64'(32'h5A5A_0000 + 32'(i)));
        end

        // Test 6: random vectors, some biased toward carry-out
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a_m[i] = (r[0]) ? (32'hF000_0000 | $urandom) : $urandom;
                b_m[i] = (r[0]) ? (32'hF000_0000 | $urandom) : $urandom;
                c_m[i] = $urandom;
            end
            full_run("t6");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
